io_unit: RTL and testbench
==========================

IO_UNIT -- requirements
Module: io_unit

Interface
REQ-001 Parameter CLKS_PER_BIT, default 43, clocks per UART bit (43 clocks x 20 ns = 860 ns bit period).
REQ-002 clock  in  1  sole clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 rx  in  1  UART serial input from DSKY host; idle high.
REQ-005 tx  out  1  UART serial output to DSKY host; idle high.
REQ-006 IO_read_sel  in  5  channel select for CPU reads.
REQ-007 IO_read_data  out  15  read data for the selected channel; combinational.
REQ-008 IO_write_sel  in  5  channel select for CPU writes.
REQ-009 IO_write_data  in  15  write data.
REQ-010 IO_write_en  in  1  write strobe; one write per asserted cycle.

Function
REQ-011 UART format SHALL be 8N1, LSB first, no parity, CLKS_PER_BIT clocks per bit, on both rx and tx.
REQ-012 rx SHALL pass through a 2-flop synchronizer before use.
REQ-013 Receiver SHALL detect the start bit on a falling edge, confirm it low at mid-bit (CLKS_PER_BIT/2), then sample each data bit and the stop bit at mid-bit.
REQ-014 A byte SHALL be valid (1-cycle pulse) only if the stop bit samples 1; a low stop bit is a framing error: byte discarded, receiver returns to idle.
REQ-015 Command parser states: IDLE, VERB_HI, VERB_LO, NOUN_HI, NOUN_LO.
REQ-016 Received '<' (0x3C) in any state SHALL move the parser to VERB_HI, discarding any partial command.
REQ-017 In each digit state, ASCII '0'-'7' SHALL be stored as a 3-bit octal digit and the parser SHALL advance VERB_HI->VERB_LO->NOUN_HI->NOUN_LO->IDLE.
REQ-018 Any other byte in a digit state SHALL return the parser to IDLE with VERB/NOUN unchanged; bytes other than '<' are ignored in IDLE.
REQ-019 On a valid digit in NOUN_LO, VERB and NOUN SHALL update together on the next clock, zero-extended to 15 bits ({hi,lo} 6-bit octal), and NEW_CMD SHALL set.
REQ-020 Read map: sel 0 = VERB; 1 = NOUN; 2 = STATUS {13'b0, tx_busy, NEW_CMD}; 3 = G; 4 = RA; 5 = RB; 6 = ATX; any other sel reads 0.
REQ-021 Writes to sel 3-6 SHALL load the 15-bit register on the clock edge; writes to sel 0, 1 and unmapped sels SHALL be ignored.
REQ-022 A write to sel 2 SHALL clear NEW_CMD; if a command completes in the same cycle, set SHALL win.
REQ-023 A write to sel 8 (DISPLAY) while tx is idle SHALL transmit 7 bytes: '<', five ASCII octal digits of IO_write_data (MSB digit = bits 14:12 first), '>'.
REQ-024 tx_busy SHALL assert the cycle after an accepted DISPLAY write and deassert after the final stop bit.
REQ-025 A DISPLAY write while tx_busy=1 SHALL be dropped without side effects.
REQ-026 Reads SHALL be side-effect free; the RX path and TX path SHALL run concurrently and independently.

Reset
REQ-027 During reset: tx=1; VERB, NOUN, G, RA, RB, ATX = 0; NEW_CMD = 0; tx_busy = 0; parser in IDLE; UART RX/TX FSMs idle with counters 0.
REQ-028 Reset asserted mid-frame or mid-transmission SHALL abort it; tx SHALL return high on the next clock edge.

Verification
REQ-029 rx bytes '<','6','1','1','6' at 860 ns/bit, one idle bit between bytes -> after the last stop bit VERB=15'o61, NOUN=15'o16, STATUS bit0=1.
REQ-030 '<','6','9','1','1' -> parser returns to IDLE at '9'; VERB/NOUN keep prior values; NEW_CMD unchanged.
REQ-031 '<','1','<','2','3','4','5' -> VERB=15'o23, NOUN=15'o45 (restart on the second '<').
REQ-032 Frame with stop bit held low -> no byte accepted, parser state unchanged.
REQ-033 Write 15'o12345 to sel 8 -> tx emits '<','1','2','3','4','5','>' at 43 clocks/bit, tx_busy high throughout; a second sel-8 write mid-transmission is dropped.
REQ-034 Write 0x1234 to sel 4, then write sel 2 -> sel 4 reads 0x1234; NEW_CMD reads 0; sel 7 reads 0.

Source files
------------

// File: rtl/io_unit.sv
`default_nettype none
// =============================================================================
// io_unit: DSKY UART bridge - 8N1 receiver feeding a <VVNN command parser,
// CPU-visible register file, and a 7-byte DISPLAY transmitter.
// Revision: 1.0
// =============================================================================
module io_unit #(
   parameter int CLKS_PER_BIT = 43
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        rx,
   output logic        tx,
   input  logic [4:0]  IO_read_sel,
   output logic [14:0] IO_read_data,
   input  logic [4:0]  IO_write_sel,
   input  logic [14:0] IO_write_data,
   input  logic        IO_write_en
);
   localparam int              CW       = $clog2(CLKS_PER_BIT + 1);
   localparam logic [CW-1:0]   BIT_END  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0]   HALF_END = CW'(CLKS_PER_BIT / 2 - 1);

   localparam logic [1:0] U_IDLE = 2'd0, U_START = 2'd1, U_DATA = 2'd2, U_STOP = 2'd3;
   localparam logic [2:0] P_IDLE = 3'd0, P_VERB_HI = 3'd1, P_VERB_LO = 3'd2,
                          P_NOUN_HI = 3'd3, P_NOUN_LO = 3'd4;

   // ---------------- receiver ----------------
   logic          rx_meta, rx_sync, rx_prev;
   logic [1:0]    rx_state, rx_next;
   logic [CW-1:0] rx_cnt;
   logic [2:0]    rx_bit;
   logic [7:0]    rx_shift;
   logic          rx_valid;

   always_ff @(posedge clock) begin
      if (reset) begin
         rx_meta  <= 1'b1;
         rx_sync  <= 1'b1;
         rx_prev  <= 1'b1;
         rx_state <= U_IDLE;
      end else begin
         rx_meta  <= rx;
         rx_sync  <= rx_meta;
         rx_prev  <= rx_sync;
         rx_state <= rx_next;
      end
   end

   always_comb begin
      rx_next = rx_state;
      case (rx_state)
         U_IDLE:  if (rx_prev && !rx_sync) rx_next = U_START;
         U_START: if (rx_cnt == HALF_END) rx_next = rx_sync ? U_IDLE : U_DATA;
         U_DATA:  if (rx_cnt == BIT_END && rx_bit == 3'd7) rx_next = U_STOP;
         default: if (rx_cnt == BIT_END) rx_next = U_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         rx_cnt   <= '0;
         rx_bit   <= 3'd0;
         rx_shift <= 8'd0;
      end else begin
         if (rx_state == U_IDLE || rx_cnt == BIT_END ||
             (rx_state == U_START && rx_cnt == HALF_END))
            rx_cnt <= '0;
         else
            rx_cnt <= rx_cnt + 1'b1;
         if (rx_state == U_IDLE)
            rx_bit <= 3'd0;
         else if (rx_state == U_DATA && rx_cnt == BIT_END) begin
            rx_shift <= {rx_sync, rx_shift[7:1]};
            rx_bit   <= rx_bit + 3'd1;
         end
      end
   end

   // A low stop bit never raises rx_valid, so framing errors are silently dropped.
   always_comb rx_valid = (rx_state == U_STOP) && (rx_cnt == BIT_END) && rx_sync;

   // ---------------- command parser ----------------
   logic [2:0]  p_state, p_next;
   logic        is_open, is_digit, cmd_done;
   logic [2:0]  v_hi, v_lo, n_hi;
   logic [14:0] verb, noun;
   logic        new_cmd;

   always_comb begin
      is_open  = (rx_shift == 8'h3C);
      is_digit = (rx_shift[7:3] == 5'b00110);
   end

   always_ff @(posedge clock) begin
      if (reset) p_state <= P_IDLE;
      else       p_state <= p_next;
   end

   always_comb begin
      p_next = p_state;
      if (rx_valid) begin
         if (is_open)
            p_next = P_VERB_HI;
         else if (!is_digit || p_state == P_NOUN_LO)
            p_next = P_IDLE;
         else if (p_state != P_IDLE)
            p_next = p_state + 3'd1;
      end
   end

   always_comb cmd_done = rx_valid && !is_open && is_digit && (p_state == P_NOUN_LO);

   // ---------------- transmitter ----------------
   logic [1:0]    tx_state, tx_next;
   logic [CW-1:0] tx_cnt;
   logic [2:0]    tx_bit, tx_idx;
   logic [14:0]   tx_word;
   logic [7:0]    tx_byte;
   logic          tx_accept, tx_busy;

   always_comb tx_accept = IO_write_en && (IO_write_sel == 5'd8) && (tx_state == U_IDLE);

   always_ff @(posedge clock) begin
      if (reset) tx_state <= U_IDLE;
      else       tx_state <= tx_next;
   end

   always_comb begin
      tx_next = tx_state;
      case (tx_state)
         U_IDLE:  if (tx_accept) tx_next = U_START;
         U_START: if (tx_cnt == BIT_END) tx_next = U_DATA;
         U_DATA:  if (tx_cnt == BIT_END && tx_bit == 3'd7) tx_next = U_STOP;
         default: if (tx_cnt == BIT_END) tx_next = (tx_idx == 3'd6) ? U_IDLE : U_START;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         tx_cnt  <= '0;
         tx_bit  <= 3'd0;
         tx_idx  <= 3'd0;
         tx_word <= 15'd0;
      end else begin
         if (tx_state == U_IDLE || tx_cnt == BIT_END) tx_cnt <= '0;
         else                                         tx_cnt <= tx_cnt + 1'b1;
         if (tx_accept) begin
            tx_word <= IO_write_data;
            tx_idx  <= 3'd0;
            tx_bit  <= 3'd0;
         end else if (tx_cnt == BIT_END) begin
            if (tx_state == U_DATA) tx_bit <= tx_bit + 3'd1;
            if (tx_state == U_STOP) tx_idx <= tx_idx + 3'd1;
         end
      end
   end

   always_comb begin
      case (tx_idx)
         3'd0:    tx_byte = 8'h3C;
         3'd1:    tx_byte = {5'b00110, tx_word[14:12]};
         3'd2:    tx_byte = {5'b00110, tx_word[11:9]};
         3'd3:    tx_byte = {5'b00110, tx_word[8:6]};
         3'd4:    tx_byte = {5'b00110, tx_word[5:3]};
         3'd5:    tx_byte = {5'b00110, tx_word[2:0]};
         default: tx_byte = 8'h3E;
      endcase
   end

   always_comb begin
      tx_busy = (tx_state != U_IDLE);
      case (tx_state)
         U_START: tx = 1'b0;
         U_DATA:  tx = tx_byte[tx_bit];
         default: tx = 1'b1;
      endcase
   end

   // ---------------- CPU register file ----------------
   logic [14:0] g_reg, ra_reg, rb_reg, atx_reg;

   always_ff @(posedge clock) begin
      if (reset) begin
         v_hi <= 3'd0;  v_lo <= 3'd0;  n_hi <= 3'd0;
         verb <= 15'd0; noun <= 15'd0; new_cmd <= 1'b0;
         g_reg <= 15'd0; ra_reg <= 15'd0; rb_reg <= 15'd0; atx_reg <= 15'd0;
      end else begin
         if (rx_valid && is_digit) begin
            if (p_state == P_VERB_HI) v_hi <= rx_shift[2:0];
            if (p_state == P_VERB_LO) v_lo <= rx_shift[2:0];
            if (p_state == P_NOUN_HI) n_hi <= rx_shift[2:0];
         end
         if (cmd_done) begin
            verb <= {9'd0, v_hi, v_lo};
            noun <= {9'd0, n_hi, rx_shift[2:0]};
         end
         // A completing command beats a simultaneous STATUS clear.
         if (cmd_done)                                      new_cmd <= 1'b1;
         else if (IO_write_en && IO_write_sel == 5'd2)      new_cmd <= 1'b0;
         if (IO_write_en) begin
            case (IO_write_sel)
               5'd3:    g_reg   <= IO_write_data;
               5'd4:    ra_reg  <= IO_write_data;
               5'd5:    rb_reg  <= IO_write_data;
               5'd6:    atx_reg <= IO_write_data;
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      case (IO_read_sel)
         5'd0:    IO_read_data = verb;
         5'd1:    IO_read_data = noun;
         5'd2:    IO_read_data = {13'd0, tx_busy, new_cmd};
         5'd3:    IO_read_data = g_reg;
         5'd4:    IO_read_data = ra_reg;
         5'd5:    IO_read_data = rb_reg;
         5'd6:    IO_read_data = atx_reg;
         default: IO_read_data = 15'd0;
      endcase
   end
endmodule
`default_nettype wire

// File: tb/tb_io_unit.sv
`default_nettype none
// tb_io_unit: directed self-checking bench for io_unit (UART command parser,
// register file and DISPLAY transmitter).
module tb_io_unit;
   localparam int CPB = 43;

   logic        clock = 1'b0;
   logic        reset;
   logic        rx;
   logic        tx;
   logic [4:0]  IO_read_sel;
   logic [14:0] IO_read_data;
   logic [4:0]  IO_write_sel;
   logic [14:0] IO_write_data;
   logic        IO_write_en;

   int tests  = 0;
   int failed = 0;

   io_unit #(.CLKS_PER_BIT(CPB)) dut (
      .clock         (clock),
      .reset         (reset),
      .rx            (rx),
      .tx            (tx),
      .IO_read_sel   (IO_read_sel),
      .IO_read_data  (IO_read_data),
      .IO_write_sel  (IO_write_sel),
      .IO_write_data (IO_write_data),
      .IO_write_en   (IO_write_en)
   );

   always #10 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic read_chk(input string tag, input logic [4:0] sel, input logic [14:0] exp);
      @(negedge clock);
      IO_read_sel = sel;
      #1;
      check(tag, {17'd0, IO_read_data}, {17'd0, exp});
   endtask

   task automatic cpu_write(input logic [4:0] sel, input logic [14:0] data);
      @(negedge clock);
      IO_write_sel  = sel;
      IO_write_data = data;
      IO_write_en   = 1'b1;
      @(negedge clock);
      IO_write_en   = 1'b0;
   endtask

   // One 8N1 frame followed by one idle bit time.
   task automatic send_byte(input logic [7:0] b, input logic stop);
      @(negedge clock);
      rx = 1'b0;
      repeat (CPB) @(negedge clock);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (CPB) @(negedge clock);
      end
      rx = stop;
      repeat (CPB) @(negedge clock);
      rx = 1'b1;
      repeat (CPB) @(negedge clock);
   endtask

   // First character sits in the most significant occupied byte.
   task automatic send_seq(input logic [55:0] s, input int n);
      for (int k = 0; k < n; k++)
         send_byte(s[8*(n-1-k) +: 8], 1'b1);
   endtask

   // Decodes one byte from tx; returns after sampling the stop bit mid-bit.
   task automatic get_tx_byte(output logic [7:0] b);
      int n = 0;
      b = 8'h00;
      while (tx !== 1'b0 && n < 2000) begin
         @(negedge clock);
         n++;
      end
      check("tx_start_timeout", (n < 2000), 1);
      if (n >= 2000) return;
      repeat (CPB / 2) @(negedge clock);
      for (int i = 0; i < 8; i++) begin
         repeat (CPB) @(negedge clock);
         b[i] = tx;
      end
      repeat (CPB) @(negedge clock);
      check("tx_stop_bit", tx, 1);
   endtask

   initial begin
      logic [7:0]  got;
      logic [55:0] exp_tx;
      bit          saw_low;

      reset = 1'b1; rx = 1'b1; IO_read_sel = 5'd0;
      IO_write_sel = 5'd0; IO_write_data = 15'd0; IO_write_en = 1'b0;
      repeat (3) @(negedge clock);
      check("reset_tx", tx, 1);
      for (int s = 0; s < 7; s++) read_chk("reset_reg", 5'(s), 15'd0);
      @(negedge clock);
      reset = 1'b0;
      repeat (5) @(negedge clock);

      // Full command <6116
      send_seq("<6116", 5);
      read_chk("cmd1_verb",   5'd0, 15'o61);
      read_chk("cmd1_noun",   5'd1, 15'o16);
      read_chk("cmd1_status", 5'd2, 15'd1);

      // Non-octal digit aborts; trailing digits ignored in IDLE
      send_seq("<6911", 5);
      read_chk("abort_verb",   5'd0, 15'o61);
      read_chk("abort_noun",   5'd1, 15'o16);
      read_chk("abort_status", 5'd2, 15'd1);

      cpu_write(5'd2, 15'd0);
      read_chk("clear_status", 5'd2, 15'd0);

      // Second '<' restarts the command
      send_seq("<1<2345", 7);
      read_chk("restart_verb",   5'd0, 15'o23);
      read_chk("restart_noun",   5'd1, 15'o45);
      read_chk("restart_status", 5'd2, 15'd1);

      // '7' with a low stop bit must not advance the parser
      cpu_write(5'd2, 15'd0);
      send_byte(8'h3C, 1'b1);
      send_byte(8'h37, 1'b0);
      read_chk("frame_err_status", 5'd2, 15'd0);
      send_seq("1234", 4);
      read_chk("frame_err_verb", 5'd0, 15'o12);
      read_chk("frame_err_noun", 5'd1, 15'o34);

      // Register file writes; VERB/NOUN and unmapped selects are read-only
      cpu_write(5'd0, 15'h7FFF);
      cpu_write(5'd1, 15'h7FFF);
      cpu_write(5'd9, 15'h7FFF);
      read_chk("verb_ro", 5'd0, 15'o12);
      read_chk("noun_ro", 5'd1, 15'o34);
      cpu_write(5'd3, 15'h2AAA);
      cpu_write(5'd4, 15'h1234);
      cpu_write(5'd5, 15'h0F0F);
      cpu_write(5'd6, 15'h7FFF);
      cpu_write(5'd2, 15'd0);
      read_chk("reg_g",       5'd3, 15'h2AAA);
      read_chk("reg_ra",      5'd4, 15'h1234);
      read_chk("reg_rb",      5'd5, 15'h0F0F);
      read_chk("reg_atx",     5'd6, 15'h7FFF);
      read_chk("status_clr",  5'd2, 15'd0);
      read_chk("unmapped_7",  5'd7, 15'd0);
      read_chk("unmapped_31", 5'd31, 15'd0);

      // DISPLAY transmit of 15'o12345
      exp_tx = "<12345>";
      IO_read_sel = 5'd2;
      cpu_write(5'd8, 15'o12345);
      #1;
      check("tx_busy_rise", IO_read_data[1], 1);
      check("tx_start_low", tx, 0);
      for (int k = 0; k < 7; k++) begin
         get_tx_byte(got);
         check("tx_byte", got, exp_tx[8*(6-k) +: 8]);
         check("tx_busy_mid", IO_read_data[1], 1);
         if (k == 1) cpu_write(5'd8, 15'o77777);
      end
      repeat (CPB) @(negedge clock);
      check("tx_busy_fall", IO_read_data[1], 0);
      saw_low = 1'b0;
      for (int i = 0; i < 600; i++) begin
         @(negedge clock);
         if (tx !== 1'b1) saw_low = 1'b1;
      end
      check("tx_quiet_after", saw_low, 0);

      // Reset in the middle of a transmission
      cpu_write(5'd8, 15'o00000);
      repeat (100) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      #1;
      check("reset_mid_tx", tx, 1);
      check("reset_mid_busy", IO_read_data[1], 0);
      read_chk("reset_mid_verb", 5'd0, 15'd0);
      read_chk("reset_mid_ra",   5'd4, 15'd0);
      reset = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
`default_nettype wire
